// File: rtl/pipeline_loader_pkg.sv
// Shared types and defaults for the instruction-memory program loader.
package pipeline_loader_pkg;

   localparam int unsigned DefaultAddrW = 5;
   localparam int unsigned DefaultDataW = 32;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StHold,
      StRun,
      StError
   } loader_state_e;

   function automatic int unsigned loader_depth(input int unsigned addr_w);
      return 32'd1 << addr_w;
   endfunction

endpackage

// File: rtl/loader_xor_acc.sv
// Running XOR of accepted stream words, used for the image checksum.
module loader_xor_acc #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] acc
);

   logic [DATA_W-1:0] acc_q, acc_d;

   always_comb begin
      acc_d = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = acc_q ^ din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/imem_program_loader.sv
// Streams a program image into instruction memory, then releases the core from reset.
// Optional LOADER_CHECKSUM_EN: the in_last word is an XOR checksum instead of a program word.
module imem_program_loader
   import pipeline_loader_pkg::*;
#(
   parameter int unsigned ADDR_W      = DefaultAddrW,
   parameter int unsigned DATA_W      = DefaultDataW,
   parameter int unsigned RELEASE_DLY = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              core_rst,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic              err,
   output logic [ADDR_W:0]   word_count
);

   localparam int unsigned   Depth    = loader_depth(ADDR_W);
   localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(Depth);
   localparam logic [3:0]    HoldLast = 4'(RELEASE_DLY);

   loader_state_e     state_q, state_d;
   logic [ADDR_W:0]   wc_q, wc_d;
   logic [3:0]        hold_q, hold_d;
   logic              ov_q, ov_d;
   logic              err_q, err_d;
   logic              in_ready_q, in_ready_d;
   logic              core_rst_q, core_rst_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic accept;
   logic load_start;
   logic ck_ok;

   assign accept     = (state_q == StLoad) && in_valid && in_ready_q;
   assign load_start = start && (state_q inside {StIdle, StRun, StError});

`ifdef LOADER_CHECKSUM_EN
   localparam bit CkMode = 1'b1;
   logic [DATA_W-1:0] xor_acc;

   // Every accepted word except the checksum itself folds in, dropped ones included.
   loader_xor_acc #(
      .DATA_W(DATA_W)
   ) u_xor_acc (
      .clk (clk),
      .rst (rst),
      .clr (load_start),
      .en  (accept && !in_last),
      .din (in_data),
      .acc (xor_acc)
   );

   assign ck_ok = (in_data == xor_acc);
`else
   localparam bit CkMode = 1'b0;
   assign ck_ok = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      wc_d    = wc_q;
      hold_d  = hold_q;
      ov_d    = ov_q;
      err_d   = err_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;

      case (state_q)
         StIdle, StRun, StError: begin
            if (start) begin
               state_d = StLoad;
               wc_d    = '0;
               ov_d    = 1'b0;
               err_d   = 1'b0;
            end
         end
         StLoad: begin
            if (accept) begin
               if (CkMode && in_last) begin
                  hold_d = '0;
                  if (ck_ok) begin
                     state_d = StHold;
                  end else begin
                     state_d = StError;
                     err_d   = 1'b1;
                  end
               end else begin
                  if (wc_q < DepthCnt) begin
                     we_d    = 1'b1;
                     addr_d  = wc_q[ADDR_W-1:0];
                     wdata_d = in_data;
                     wc_d    = wc_q + 1'b1;
                  end else begin
                     ov_d = 1'b1;
                  end
                  if (in_last) begin
                     state_d = StHold;
                     hold_d  = '0;
                  end
               end
            end
         end
         StHold: begin
            // Counting 0..RELEASE_DLY gives 1+RELEASE_DLY cycles from last acceptance to release.
            if (hold_q == HoldLast) begin
               state_d = StRun;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      in_ready_d = (state_d == StLoad);
      core_rst_d = (state_d != StRun);
      busy_d     = (state_d == StLoad) || (state_d == StHold);
      done_d     = (state_d == StRun);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         wc_q       <= '0;
         hold_q     <= '0;
         ov_q       <= 1'b0;
         err_q      <= 1'b0;
         in_ready_q <= 1'b0;
         core_rst_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         wc_q       <= wc_d;
         hold_q     <= hold_d;
         ov_q       <= ov_d;
         err_q      <= err_d;
         in_ready_q <= in_ready_d;
         core_rst_q <= core_rst_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign core_rst   = core_rst_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign overflow   = ov_q;
   assign err        = err_q;
   assign word_count = wc_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Scoreboard bench for imem_program_loader (ADDR_W=2, RELEASE_DLY=4).
module tb_imem_program_loader;

   localparam int unsigned AW  = 2;
   localparam int unsigned DW  = 32;
   localparam int unsigned DLY = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          in_last;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [DW-1:0] imem_wdata;
   logic          core_rst;
   logic          busy;
   logic          done;
   logic          overflow;
   logic          err;
   logic [AW:0]   word_count;

   imem_program_loader #(
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .RELEASE_DLY (DLY)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_rst   (core_rst),
      .busy       (busy),
      .done       (done),
      .overflow   (overflow),
      .err        (err),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            cyc;
   } wr_t;

   wr_t exp_q[$];
   int  checks   = 0;
   int  failures = 0;
   int  last_acc = 0;

   // Monitor: every presented write must match the next expected one, in the expected cycle.
   always @(negedge clk) begin
      wr_t e;
      if (imem_we === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL write_unexpected got addr=%0d data=%h cyc=%0d, expected no write",
                     imem_addr, imem_wdata, cyc);
         end else begin
            e = exp_q.pop_front();
            if (imem_addr !== e.addr || imem_wdata !== e.data || cyc != e.cyc) begin
               failures++;
               $display("FAIL write got addr=%0d data=%h cyc=%0d, expected addr=%0d data=%h cyc=%0d",
                        imem_addr, imem_wdata, cyc, e.addr, e.data, e.cyc);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // exp_addr < 0 means the word must not produce a write.
   task automatic send_word(input logic [DW-1:0] d, input logic last, input int exp_addr);
      bit acc;
      int n;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      n        = 0;
      acc      = 1'b0;
      while (!acc && n < 50) begin
         acc = in_ready;
         tick();
         n++;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      checks++;
      if (!acc) begin
         failures++;
         $display("FAIL accept_timeout word %h not accepted, expected acceptance", d);
      end else begin
         last_acc = cyc;
         if (exp_addr >= 0) exp_q.push_back('{addr: AW'(exp_addr), data: d, cyc: cyc});
      end
   endtask

   task automatic wait_release(input string name);
      int n;
      n = 0;
      while (core_rst === 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(cyc), 32'(last_acc + 1 + DLY));
      #1;
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
      tick(2);
      rst = 1'b0;
      check("rst_core_rst", 32'(core_rst), 32'd1);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_word_count", 32'(word_count), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      tick(2);

      // start and in_valid together in IDLE: start wins, word not accepted
      start    = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'hBADBAD00;
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      check("start_in_ready", 32'(in_ready), 32'd1);
      check("start_busy", 32'(busy), 32'd1);
      check("start_core_rst", 32'(core_rst), 32'd1);
      tick();
      check("start_no_accept_wc", 32'(word_count), 32'd0);

`ifndef LOADER_CHECKSUM_EN
      // Basic load with a 3-cycle gap between words 2 and 3
      send_word(32'h00000013, 1'b0, 0);
      send_word(32'h00100093, 1'b0, 1);
      tick(3);
      send_word(32'h00200113, 1'b0, 2);
      send_word(32'h002081B3, 1'b1, 3);
      check("basic_hold_busy", 32'(busy), 32'd1);
      check("basic_hold_in_ready", 32'(in_ready), 32'd0);
      wait_release("basic_release_cycle");
      check("basic_done", 32'(done), 32'd1);
      check("basic_word_count", 32'(word_count), 32'd4);
      check("basic_overflow", 32'(overflow), 32'd0);
      check("basic_busy", 32'(busy), 32'd0);

      // Restart from RUN
      tick(2);
      pulse_start();
      check("rerun_core_rst", 32'(core_rst), 32'd1);
      check("rerun_done", 32'(done), 32'd0);
      check("rerun_word_count", 32'(word_count), 32'd0);

      // Overflow: 6 words into a 4-word memory
      send_word(32'h11111111, 1'b0, 0);
      send_word(32'h22222222, 1'b0, 1);
      send_word(32'h33333333, 1'b0, 2);
      send_word(32'h44444444, 1'b0, 3);
      check("ovf_not_yet", 32'(overflow), 32'd0);
      send_word(32'h55555555, 1'b0, -1);
      check("ovf_set", 32'(overflow), 32'd1);
      check("ovf_still_ready", 32'(in_ready), 32'd1);
      send_word(32'h66666666, 1'b1, -1);
      wait_release("ovf_release_cycle");
      check("ovf_word_count", 32'(word_count), 32'd4);
      check("ovf_sticky", 32'(overflow), 32'd1);
      check("ovf_done", 32'(done), 32'd1);

      // Single-word image; overflow clears on restart
      pulse_start();
      check("single_ovf_clear", 32'(overflow), 32'd0);
      send_word(32'hDEADBEEF, 1'b1, 0);
      wait_release("single_release_cycle");
      check("single_word_count", 32'(word_count), 32'd1);

      // Reset during the 2nd word
      pulse_start();
      send_word(32'h0000AAAA, 1'b0, 0);
      in_valid = 1'b1;
      in_data  = 32'h0000BBBB;
      rst      = 1'b1;
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_core_rst", 32'(core_rst), 32'd1);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      check("midrst_word_count", 32'(word_count), 32'd0);
      tick(5);
      pulse_start();
      send_word(32'h0000CCCC, 1'b0, 0);
      send_word(32'h0000DDDD, 1'b1, 1);
      wait_release("midrst_release_cycle");
      check("midrst_reload_wc", 32'(word_count), 32'd2);
`else
      // Matching checksum
      send_word(32'h1, 1'b0, 0);
      send_word(32'h2, 1'b0, 1);
      send_word(32'h3, 1'b1, -1);
      wait_release("ck_ok_release_cycle");
      check("ck_ok_done", 32'(done), 32'd1);
      check("ck_ok_err", 32'(err), 32'd0);
      check("ck_ok_word_count", 32'(word_count), 32'd2);

      // Mismatching checksum
      pulse_start();
      send_word(32'h1, 1'b0, 0);
      send_word(32'h2, 1'b0, 1);
      send_word(32'h4, 1'b1, -1);
      check("ck_bad_err", 32'(err), 32'd1);
      check("ck_bad_busy", 32'(busy), 32'd0);
      tick(8);
      check("ck_bad_core_rst", 32'(core_rst), 32'd1);
      check("ck_bad_done", 32'(done), 32'd0);
      check("ck_bad_err_sticky", 32'(err), 32'd1);

      // Recovery
      pulse_start();
      check("ck_recover_err", 32'(err), 32'd0);
      check("ck_recover_busy", 32'(busy), 32'd1);
      send_word(32'h5, 1'b0, 0);
      send_word(32'h5, 1'b1, -1);
      wait_release("ck_recover_release_cycle");
      check("ck_recover_done", 32'(done), 32'd1);
`endif

      tick(3);
      check("pending_writes", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
